// File: rtl/resp_demux_pkg.sv
// Shared definitions for the registered 1-to-2 response demultiplexer.
// Holds the select encodings and the per-slot state encoding.
package resp_demux_pkg;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with EMPTY/FULL state for one demux destination.
// With DEMUX_STATS_EN defined, also counts drains (wrapping at 2^CNT_W).
module demux_slot
  import resp_demux_pkg::*;
#(
  parameter int width = 31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [width:0]   in_data,
  input  logic             out_ready,
  output logic [width:0]   out_data,
  output logic             out_valid
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e          state_r;
  slot_state_e          state_s;
  logic [width:0]       data_r;

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: an accept always leaves the slot FULL, which covers
  // the drain-and-refill case without a bubble.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (accept) begin
          state_s = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // Payload register; holds its last value after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {(width+1){1'b0}};
    end else if (accept) begin
      data_r <= in_data;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_r;

  // Drain counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;
`endif

endmodule

// File: rtl/resp_demux.sv
// Registered 1-to-2 valid/ready demultiplexer, one-cycle latency per destination.
// Optional drain counters cnt1/cnt2 are built when DEMUX_STATS_EN is defined.
module resp_demux
  import resp_demux_pkg::*;
#(
  parameter int width = 31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width:0]   in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width:0]   out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [width:0]   out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);

  logic accept1_s;
  logic accept2_s;

  // Ready follows only the selected slot, so a stalled slot never blocks the other.
  assign in_ready  = (in_sel == SEL_OUT1) ? (~out1_valid | out1_ready)
                                          : (~out2_valid | out2_ready);
  assign accept1_s = in_valid & in_ready & (in_sel == SEL_OUT1);
  assign accept2_s = in_valid & in_ready & (in_sel == SEL_OUT2);

  demux_slot #(.width(width), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept1_s),
    .in_data   (in_data),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .out_valid (out1_valid)
`ifdef DEMUX_STATS_EN
    ,
    .cnt       (cnt1)
`endif
  );

  demux_slot #(.width(width), .CNT_W(CNT_W)) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept2_s),
    .in_data   (in_data),
    .out_ready (out2_ready),
    .out_data  (out2_data),
    .out_valid (out2_valid)
`ifdef DEMUX_STATS_EN
    ,
    .cnt       (cnt2)
`endif
  );

endmodule

// File: tb/tb_resp_demux.sv
// Directed self-checking bench for resp_demux; the counter scenario is
// built only when DEMUX_STATS_EN is defined.
module tb_resp_demux;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2_data;
  logic        out2_valid;
  logic        out2_ready;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
`endif

  integer n_cmp;
  integer n_err;

  resp_demux #(.width(31), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX_STATS_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; in_data = 32'h0; in_sel = 1'b0; in_valid = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL reset_v1 got %b exp 0", out1_valid); end
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL reset_v2 got %b exp 0", out2_valid); end
    n_cmp++; if (out1_data !== 32'h0) begin n_err++; $display("FAIL reset_d1 got %h exp 0", out1_data); end
    n_cmp++; if (out2_data !== 32'h0) begin n_err++; $display("FAIL reset_d2 got %h exp 0", out2_data); end
    rst = 1'b0;
    // fill slot1, then reset between edges
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL prefill got v=%b d=%h exp v=1 d=deadbeef", out1_valid, out1_data); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL midrst_v1 got %b exp 0", out1_valid); end
    n_cmp++; if (out1_data !== 32'h0) begin n_err++; $display("FAIL midrst_d1 got %h exp 0", out1_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_rdy got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    out2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out2_valid !== 1'b1 || out2_data !== 32'h12345678) begin
      n_err++; $display("FAIL single_out2 got v=%b d=%h exp v=1 d=12345678", out2_valid, out2_data); end
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL single_out1 got %b exp 0", out1_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL single_drop got %b exp 0", out2_valid); end
  endtask

  task automatic test_back_to_back;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = i[0]; in_data = i;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy[%0d] got %b exp 1", i, in_ready); end
      @(posedge clk); #1;
      if (i[0] == 1'b0) begin
        n_cmp++; if (out1_valid !== 1'b1 || out1_data !== i) begin
          n_err++; $display("FAIL b2b_out1[%0d] got v=%b d=%h exp v=1 d=%h", i, out1_valid, out1_data, i); end
      end else begin
        n_cmp++; if (out2_valid !== 1'b1 || out2_data !== i) begin
          n_err++; $display("FAIL b2b_out2[%0d] got v=%b d=%h exp v=1 d=%h", i, out2_valid, out2_data, i); end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got v1=%b v2=%b exp 0 0", out1_valid, out2_valid); end
  endtask

  task automatic test_independent_blocking;
    out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
    @(posedge clk); #1;
    in_data = 32'hB;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL blk_rdy_b got %b exp 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hA) begin
      n_err++; $display("FAIL blk_hold got v=%b d=%h exp v=1 d=a", out1_valid, out1_data); end
    in_sel = 1'b1; in_data = 32'hC;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL blk_rdy_c got %b exp 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out2_valid !== 1'b1 || out2_data !== 32'hC) begin
      n_err++; $display("FAIL blk_out2 got v=%b d=%h exp v=1 d=c", out2_valid, out2_data); end
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hA) begin
      n_err++; $display("FAIL blk_out1_held got v=%b d=%h exp v=1 d=a", out1_valid, out1_data); end
    // release: 0xA drains at this edge, 0xB loads
    out1_ready = 1'b1; out2_ready = 1'b1;
    in_sel = 1'b0; in_data = 32'hB;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL blk_rdy_rel got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hB) begin
      n_err++; $display("FAIL blk_order got v=%b d=%h exp v=1 d=b", out1_valid, out1_data); end
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL blk_out2_drain got %b exp 0", out2_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out1_valid !== 1'b0) begin n_err++; $display("FAIL blk_out1_drain got %b exp 0", out1_valid); end
  endtask

  task automatic test_accept_drain;
    out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h1;
    @(posedge clk); #1;
    out2_ready = 1'b1; in_data = 32'h2;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ad_rdy got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out2_valid !== 1'b1 || out2_data !== 32'h2) begin
      n_err++; $display("FAIL ad_out2 got v=%b d=%h exp v=1 d=2", out2_valid, out2_data); end
    @(posedge clk); #1;
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL ad_drain got %b exp 0", out2_valid); end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    #1;
    n_cmp++; if (cnt1 !== 16'h0 || cnt2 !== 16'h0) begin
      n_err++; $display("FAIL st_reset got c1=%h c2=%h exp 0 0", cnt1, cnt2); end
    @(negedge clk);
    rst = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (cnt1 !== 16'hFFFF) begin n_err++; $display("FAIL st_full got %h exp ffff", cnt1); end
    n_cmp++; if (cnt2 !== 16'h0) begin n_err++; $display("FAIL st_c2a got %h exp 0", cnt2); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (cnt1 !== 16'h0) begin n_err++; $display("FAIL st_wrap got %h exp 0", cnt1); end
    n_cmp++; if (cnt2 !== 16'h0) begin n_err++; $display("FAIL st_c2b got %h exp 0", cnt2); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_independent_blocking();
    test_accept_drain();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
